// File: rtl/pchb_pkg.sv
// Shared definitions for the PCHB merge: dual-rail codes, select codes,
// the two-state token FSM encoding and small rail-decoding helpers.
package pchb_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  localparam logic [1:0] SEL_L0  = 2'b01;
  localparam logic [1:0] SEL_L1  = 2'b10;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // A single rail pair carries a data value (0 or 1)
  function automatic logic pair_is_data(input logic [1:0] pair);
    return (pair == DR_0) || (pair == DR_1);
  endfunction

  // A single rail pair has both rails high, which no sender may produce
  function automatic logic pair_is_ill(input logic [1:0] pair);
    return pair == DR_ILL;
  endfunction

endpackage

// File: rtl/pchb_merge_sync_dr_complete.sv
// Dual-rail completion detector: reports whether every pair of a bus
// carries data, whether every pair is null, and whether any pair is illegal.
module dr_complete
  import pchb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [2*WIDTH-1:0] data,
  output logic               all_valid,
  output logic               all_null,
  output logic               any_ill
);

  logic [1:0] pair;

  // Walk the rail pairs and fold them into the three completion flags
  always_comb begin
    all_valid = 1'b1;
    all_null  = 1'b1;
    any_ill   = 1'b0;
    pair      = DR_NULL;
    for (int i = 0; i < WIDTH; i++) begin
      pair = data[2*i +: 2];
      if (!pair_is_data(pair)) all_valid = 1'b0;
      if (pair != DR_NULL)     all_null  = 1'b0;
      if (pair_is_ill(pair))   any_ill   = 1'b1;
    end
  end

endmodule

// File: rtl/pchb_merge_sync.sv
// Clocked two-input PCHB merge. A dual-rail select picks L0 or L1; the
// chosen token is registered onto R and held until the four-phase return
// to null. Optional illegal-code checker enabled by macro PCHB_MERGE_CHK_EN,
// which adds a sticky err output.
module pchb_merge_sync
  import pchb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [2*WIDTH-1:0] L0,
  output logic               L0e,
  input  logic [2*WIDTH-1:0] L1,
  output logic               L1e,
  input  logic [1:0]         sel,
  output logic               sele,
  output logic [2*WIDTH-1:0] R,
  input  logic               Re
`ifdef PCHB_MERGE_CHK_EN
  ,
  output logic               err
`endif
);

  state_t             state_q, state_d;
  logic               chan_q, chan_d;
  logic [2*WIDTH-1:0] r_q, r_d;
  logic               l0e_q, l0e_d;
  logic               l1e_q, l1e_d;
  logic               sele_q, sele_d;

  logic l0_valid, l0_null, l0_ill;
  logic l1_valid, l1_null, l1_ill;
  logic sel_valid, sel_null, sel_ill;

  logic take_l1;
  logic cand_valid;
  logic cand_ill;
  logic held_null;
  logic do_transfer;
  logic do_release;

  dr_complete #(.WIDTH(WIDTH)) u_l0_complete (
    .data      (L0),
    .all_valid (l0_valid),
    .all_null  (l0_null),
    .any_ill   (l0_ill)
  );

  dr_complete #(.WIDTH(WIDTH)) u_l1_complete (
    .data      (L1),
    .all_valid (l1_valid),
    .all_null  (l1_null),
    .any_ill   (l1_ill)
  );

  dr_complete #(.WIDTH(1)) u_sel_complete (
    .data      (sel),
    .all_valid (sel_valid),
    .all_null  (sel_null),
    .any_ill   (sel_ill)
  );

  // Decode which channel the select points at and the handshake conditions;
  // illegal codes are excluded explicitly so they can never be consumed
  always_comb begin
    take_l1     = (sel == SEL_L1);
    cand_valid  = take_l1 ? l1_valid : l0_valid;
    cand_ill    = take_l1 ? l1_ill   : l0_ill;
    held_null   = chan_q  ? l1_null  : l0_null;
    do_transfer = Re && sel_valid && !sel_ill && cand_valid && !cand_ill;
    do_release  = !Re && sel_null && held_null;
  end

  // Next-state and next-output logic for the EMPTY/FULL token FSM
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    r_d     = r_q;
    l0e_d   = l0e_q;
    l1e_d   = l1e_q;
    sele_d  = sele_q;
    case (state_q)
      EMPTY: begin
        if (do_transfer) begin
          state_d = FULL;
          chan_d  = take_l1;
          r_d     = take_l1 ? L1 : L0;
          sele_d  = 1'b0;
          if (take_l1) l1e_d = 1'b0;
          else         l0e_d = 1'b0;
        end
      end
      FULL: begin
        if (do_release) begin
          state_d = EMPTY;
          r_d     = '0;
          sele_d  = 1'b1;
          l0e_d   = 1'b1;
          l1e_d   = 1'b1;
        end
      end
    endcase
  end

  // Registered state and outputs; reset wins over any handshake in flight
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= EMPTY;
      chan_q  <= 1'b0;
      r_q     <= '0;
      l0e_q   <= 1'b1;
      l1e_q   <= 1'b1;
      sele_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      r_q     <= r_d;
      l0e_q   <= l0e_d;
      l1e_q   <= l1e_d;
      sele_q  <= sele_d;
    end
  end

  assign R    = r_q;
  assign L0e  = l0e_q;
  assign L1e  = l1e_q;
  assign sele = sele_q;

`ifdef PCHB_MERGE_CHK_EN
  logic err_q;
  logic err_set;

  // An illegal select, or an illegal selected channel while waiting, flags an error
  always_comb begin
    err_set = sel_ill || ((state_q == EMPTY) && sel_valid && cand_ill);
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RESET) err_q <= 1'b0;
    else       err_q <= err_q | err_set;
  end

  assign err = err_q;
`endif

endmodule

// File: doc/pchb_merge_sync.md
Name: pchb_merge_sync

Overview:
- Clocked, cycle-based two-input merge for the router's dual-rail four-phase channels. It is the counterpart of the PCHB split.
- A dual-rail select token chooses input channel L0 or L1. The chosen token is forwarded to the single output R, and the consumed input and the select are acknowledged.
- Used in router output ports to recombine traffic, and as the golden reference in mixed clocked/async benches.

Parameters:
- WIDTH, 1, number of dual-rail data bits per channel; each data port is 2*WIDTH wires.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- L0  input  2*WIDTH  dual-rail data, input channel 0
- L0e  output  1  enable/ack for L0 (1 = request data, 0 = request null)
- L1  input  2*WIDTH  dual-rail data, input channel 1
- L1e  output  1  enable/ack for L1
- sel  input  2  dual-rail select (01 = take L0, 10 = take L1)
- sele  output  1  enable/ack for sel
- R  output  2*WIDTH  dual-rail output data
- Re  input  1  output enable from receiver (1 = ready for data, 0 = ready for null)

Behaviour:
- Rail code per bit pair: 00 null, 01 data 0, 10 data 1, 11 illegal.
  - A channel is valid when every pair is 01 or 10.
  - A channel is null when every pair is 00.
  - Illegal pairs make a channel neither valid nor null.
- Reset (RESET=1 at a rising edge): R=0 (all null), L0e=1, L1e=1, sele=1, state=EMPTY.
- Reset is synchronous and overrides everything, including mid-handshake. The next edge restores reset values; no token is held.
- State EMPTY:
  - Transfer condition: Re=1 AND sel valid AND the selected channel is valid.
  - When it holds, on that edge: R <= selected L; sele <= 0; selected enable <= 0; state <= FULL.
  - Latency is 1 cycle from the condition to R valid.
  - The unselected channel's enable stays 1 and its data is ignored.
  - If sel is valid but the selected channel is only partially valid, wait.
  - If sel is null or illegal, wait regardless of L0/L1.
- State FULL:
  - R holds the data.
  - Release condition: Re=0 AND sel null AND the previously selected channel null.
  - When it holds, on that edge: R <= null; sele <= 1; selected enable <= 1; state <= EMPTY.
  - The selected channel is registered in a 1-bit flag captured at transfer.
  - Changes on sel or L during FULL never alter R.
- Re low while EMPTY: no transfer. The next data waits for Re=1, enforcing the four-phase return to zero.
- Both channels valid simultaneously: only the selected one is consumed. The other stays pending with its enable at 1, and a later sel can take it.
- Back-to-back tokens: a minimum of 2 cycles per token (one EMPTY→FULL edge, one FULL→EMPTY edge).
- Enables and R are registered outputs; there are no combinational input-to-output paths.

Optional Feature:
- Macro: PCHB_MERGE_CHK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - err is set sticky on any edge where sel, or the selected channel in EMPTY, contains an 11 pair. It is cleared only by RESET.
  - Illegal inputs are still never consumed.
- Undefined:
  - No err port.
  - 11 pairs are silently treated as not-valid/not-null, so the block waits.

Decomposition:
- Package pchb_pkg:
  - rail constants DR_NULL=2'b00, DR_0=2'b01, DR_1=2'b10, DR_ILL=2'b11
  - state encoding EMPTY/FULL
  - select codes SEL_L0=2'b01, SEL_L1=2'b10
- Sub-module dr_complete (parameter WIDTH): completion detector with outputs all_valid, all_null, any_ill. One instance each for L0, L1 and sel (sel at WIDTH=1).

Test Plan:
- Reset: hold RESET=1 two cycles with L0=01 and sel=01 → R=00, L0e=L1e=sele=1, no transfer. Release → transfer on the next edge only if Re=1.
- Basic L0 path (WIDTH=1):
  - Stimulus: Re=1, L0=01, sel=01.
  - Next cycle: R=01, L0e=0, sele=0, L1e=1.
  - Then drop Re=0, L0=00, sel=00 → next cycle R=00, L0e=1, sele=1.
- L1 path with conflict:
  - Stimulus: L0=10 and L1=10 both valid, sel=10, Re=1.
  - Response: R=10, L1e=0, L0e stays 1.
  - After the null phase, sel=01 → R=10 taken from L0.
- Stall/hold:
  - Re=0 in EMPTY with valid inputs → R stays 00 for 5 cycles.
  - In FULL, change sel to 10 and L1 to 01 → R unchanged.
  - Release is blocked while sel ≠ 00.
- Partial validity (WIDTH=2): L0=4'b0100 (one pair null), sel=01, Re=1 → no transfer. Then L0=4'b0110 → R=4'b0110 one cycle later.
- Reset mid-FULL and checker:
  - RESET in FULL → outputs return to reset values on the next edge.
  - With PCHB_MERGE_CHK_EN, sel=11 → err=1 and stays 1 until RESET; no transfer occurs.
